// File: rtl/flevel_ramp.sv
// flevel_ramp: I/Q upconverter with a soft on/off amplitude ramp.
//   hold_i*cosd + hold_q*sind is rounded, scaled by a ramped gain, then
//   saturated and truncated to the output width. Four-stage pipeline.
// Optional build macro: FLEVEL_RAMP_SATCNT_EN (saturation event counter).
//   When undefined, sat_cnt is tied to zero and no counter is generated.
module flevel_ramp #(
   parameter int DW_IN     = 17,
   parameter int LO_W      = 18,
   parameter int DW_OUT    = 16,
   parameter int GAIN_W    = 16,
   parameter int RAMP_STEP = 4096
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [LO_W-1:0]   cosd,
   input  logic signed [LO_W-1:0]   sind,
   input  logic signed [DW_IN-1:0]  i_data,
   input  logic                     i_gate,
   input  logic signed [DW_IN-1:0]  q_data,
   input  logic                     q_gate,
   input  logic                     enable,
   input  logic                     err_clr,
   output logic signed [DW_OUT-1:0] o_data,
   output logic                     o_gate,
   output logic [1:0]               ramp_state,
   output logic                     time_err,
   output logic [15:0]              sat_cnt
);

   localparam int P  = DW_IN + LO_W;        // LO product width
   localparam int SW = DW_IN + 1;           // rounded sum / scaled width
   localparam int PW = SW + GAIN_W + 1;     // gain product width

   localparam logic [GAIN_W-1:0] GMAX  = '1;
   localparam logic [GAIN_W-1:0] GSTEP = GAIN_W'(RAMP_STEP);
   localparam logic [DW_IN-1:0]  SMAX  = {1'b0, {(DW_IN-1){1'b1}}};
   localparam logic [DW_IN-1:0]  SMIN  = {1'b1, {(DW_IN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      ON   = 2'd2,
      DOWN = 2'd3
   } ramp_t;

   ramp_t                    state_q, state_d;
   logic [GAIN_W-1:0]        g_q, g_d;
   logic [GAIN_W:0]          up_sum;

   logic signed [DW_IN-1:0]  hold_i_q, hold_q_q;
   logic                     err_q, err_d;

   logic signed [P-1:0]      pc_q, pc_d, ps_q, ps_d;
   logic signed [DW_IN-1:0]  pc_s, ps_s;
   logic signed [SW-1:0]     sum_q, sum_d;
   logic signed [GAIN_W:0]   gain_s;
   logic signed [PW-1:0]     prod, prod_sh;
   logic signed [SW-1:0]     scl_q, scl_d;
   logic                     clamp;
   logic [DW_IN-1:0]         sat_v;
   logic signed [DW_OUT-1:0] o_data_q, o_data_d;
   logic [1:0]               gate_q;

   // Sample capture: each hold register keeps its value between strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_i_q <= '0;
         hold_q_q <= '0;
      end else begin
         if (i_gate) hold_i_q <= i_data;
         if (q_gate) hold_q_q <= q_data;
      end
   end

   // Sticky strobe-mismatch flag; a new mismatch beats a simultaneous clear
   always_comb begin
      err_d = err_q;
      if (i_gate != q_gate) err_d = 1'b1;
      else if (err_clr)     err_d = 1'b0;
   end

   // Mismatch flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   // Ramp FSM state and gain registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         g_q     <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
      end
   end

   // Ramp FSM next state and gain step; a direction change skips that cycle's step
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      up_sum  = {1'b0, g_q} + {1'b0, GSTEP};
      case (state_q)
         IDLE: begin
            g_d = '0;
            if (enable) state_d = UP;
         end
         UP: begin
            if (!enable) begin
               state_d = DOWN;
            end else if (g_q == GMAX) begin
               state_d = ON;
            end else begin
               g_d = up_sum[GAIN_W] ? GMAX : up_sum[GAIN_W-1:0];
            end
         end
         ON: begin
            g_d = GMAX;
            if (!enable) state_d = DOWN;
         end
         DOWN: begin
            if (enable) begin
               state_d = UP;
            end else if (g_q == '0) begin
               state_d = IDLE;
            end else begin
               g_d = (g_q > GSTEP) ? (g_q - GSTEP) : '0;
            end
         end
         default: begin
            state_d = IDLE;
            g_d     = '0;
         end
      endcase
   end

   // Datapath stage logic: LO multiply, round, gain scale, saturate
   always_comb begin
      pc_d     = P'(hold_i_q) * P'(cosd);
      ps_d     = P'(hold_q_q) * P'(sind);
      pc_s     = pc_q[P-2:LO_W-1];
      ps_s     = ps_q[P-2:LO_W-1];
      sum_d    = SW'(pc_s) + SW'(ps_s) + SW'(1);
      gain_s   = $signed({1'b0, g_q});
      prod     = PW'(sum_q) * PW'(gain_s);
      prod_sh  = prod >>> GAIN_W;
      scl_d    = prod_sh[SW-1:0];
      clamp    = scl_q[SW-1] ^ scl_q[SW-2];
      sat_v    = clamp ? (scl_q[SW-1] ? SMIN : SMAX) : scl_q[DW_IN-1:0];
      o_data_d = sat_v[DW_IN-1 -: DW_OUT];
   end

   // Datapath pipeline registers S1..S4
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= '0;
         ps_q     <= '0;
         sum_q    <= '0;
         scl_q    <= '0;
         o_data_q <= '0;
      end else begin
         pc_q     <= pc_d;
         ps_q     <= ps_d;
         sum_q    <= sum_d;
         scl_q    <= scl_d;
         o_data_q <= o_data_d;
      end
   end

   // Carrier-active flag delayed two cycles to line up with S3/S4
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gate_q <= '0;
      else        gate_q <= {gate_q[0], (state_q != IDLE)};
   end

`ifdef FLEVEL_RAMP_SATCNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Saturating event counter; clear wins over a coincident increment
   always_comb begin
      cnt_d = cnt_q;
      if (err_clr)                  cnt_d = '0;
      else if (clamp && cnt_q != '1) cnt_d = cnt_q + 16'd1;
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign sat_cnt = cnt_q;
`else
   assign sat_cnt = '0;
`endif

   // Product bits outside the kept slices are intentionally discarded
   logic unused_bits;
   assign unused_bits = ^{pc_q[P-1], pc_q[LO_W-2:0], ps_q[P-1], ps_q[LO_W-2:0],
                          prod_sh[PW-1:SW], sat_v};

   assign o_data     = o_data_q;
   assign o_gate     = gate_q[1];
   assign ramp_state = state_q;
   assign time_err   = err_q;

endmodule

// File: tb/tb_flevel_ramp.sv
// Directed self-checking bench for flevel_ramp (default parameters).
module tb_flevel_ramp;

   logic               clk;
   logic               rst_n;
   logic signed [17:0] cosd, sind;
   logic signed [16:0] i_data, q_data;
   logic               i_gate, q_gate, enable, err_clr;
   logic signed [15:0] o_data;
   logic               o_gate;
   logic [1:0]         ramp_state;
   logic               time_err;
   logic [15:0]        sat_cnt;

   int tests  = 0;
   int failed = 0;
   int maxd;
   int prev_g;
   int d;

   flevel_ramp #(
      .DW_IN(17), .LO_W(18), .DW_OUT(16), .GAIN_W(16), .RAMP_STEP(4096)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cosd(cosd), .sind(sind),
      .i_data(i_data), .i_gate(i_gate), .q_data(q_data), .q_gate(q_gate),
      .enable(enable), .err_clr(err_clr), .o_data(o_data), .o_gate(o_gate),
      .ramp_state(ramp_state), .time_err(time_err), .sat_cnt(sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

`ifdef FLEVEL_RAMP_SATCNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   initial begin
      // 1: reset with random inputs
      rst_n = 1'b0;
      repeat (4) begin
         cosd    = 18'($urandom);
         sind    = 18'($urandom);
         i_data  = 17'($urandom);
         q_data  = 17'($urandom);
         i_gate  = 1'($urandom);
         q_gate  = 1'($urandom);
         enable  = 1'($urandom);
         err_clr = 1'($urandom);
         tick();
      end
      chk("rst_o_data",   {16'h0, o_data}, 32'd0);
      chk("rst_o_gate",   32'(o_gate), 32'd0);
      chk("rst_state",    32'(ramp_state), 32'd0);
      chk("rst_time_err", 32'(time_err), 32'd0);
      chk("rst_sat_cnt",  32'(sat_cnt), 32'd0);
      chk("rst_g",        32'(dut.g_q), 32'd0);

      cosd = '0; sind = '0; i_data = '0; q_data = '0;
      i_gate = 1'b0; q_gate = 1'b0; enable = 1'b0; err_clr = 1'b0;
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_o_data", {16'h0, o_data}, 32'd0);
      chk("idle_o_gate", 32'(o_gate), 32'd0);
      chk("idle_state",  32'(ramp_state), 32'd0);

      // 2: ramp up
      enable = 1'b1;
      tick();
      chk("up_state0", 32'(ramp_state), 32'd1);
      chk("up_g0",     32'(dut.g_q), 32'd0);
      tick();
      chk("up_g1",     32'(dut.g_q), 32'd4096);
      chk("up_gate1",  32'(o_gate), 32'd0);
      tick();
      chk("up_gate2",  32'(o_gate), 32'd1);
      chk("up_g2",     32'(dut.g_q), 32'd8192);
      repeat (13) tick();
      chk("up_g15",    32'(dut.g_q), 32'd61440);
      tick();
      chk("up_g16",    32'(dut.g_q), 32'd65535);
      chk("up_state16", 32'(ramp_state), 32'd1);
      tick();
      chk("on_state",  32'(ramp_state), 32'd2);
      chk("on_g",      32'(dut.g_q), 32'd65535);

      // 3: nominal carrier
      i_data = 17'sd30000; q_data = '0; i_gate = 1'b1; q_gate = 1'b1;
      cosd = 18'sd131071; sind = '0;
      tick();
      i_gate = 1'b0; q_gate = 1'b0;
      repeat (3) tick();
      chk("lat_o_data3", {16'h0, o_data}, 32'd0);
      tick();
      chk("nom_o_data4", {16'h0, o_data}, 32'd14999);
      repeat (2) tick();
      chk("nom_o_data6", {16'h0, o_data}, 32'd14999);
      chk("nom_time_err", 32'(time_err), 32'd0);

      // 4: positive overflow
      i_data = 17'sd65535; q_data = 17'sd65535; i_gate = 1'b1; q_gate = 1'b1;
      sind = 18'sd131071;
      tick();
      i_gate = 1'b0; q_gate = 1'b0;
      repeat (3) tick();
      chk("ovf_pre_o_data", {16'h0, o_data}, 32'd14999);
      chk("ovf_pre_cnt",    32'(sat_cnt), 32'd0);
      tick();
      chk("ovf_o_data", {16'h0, o_data}, 32'd32767);
      chk("ovf_cnt1",   32'(sat_cnt), CNT_ON ? 32'd1 : 32'd0);
      tick();
      chk("ovf_cnt2",   32'(sat_cnt), CNT_ON ? 32'd2 : 32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("ovf_cnt_clr", 32'(sat_cnt), 32'd0);
      tick();
      chk("ovf_cnt_again", 32'(sat_cnt), CNT_ON ? 32'd1 : 32'd0);
      chk("ovf_o_data_hold", {16'h0, o_data}, 32'd32767);

      // 5: strobe mismatch
      i_gate = 1'b1; q_gate = 1'b0;
      tick();
      i_gate = 1'b0;
      chk("terr_set", 32'(time_err), 32'd1);
      repeat (2) tick();
      chk("terr_sticky", 32'(time_err), 32'd1);
      err_clr = 1'b1;
      tick();
      chk("terr_clr", 32'(time_err), 32'd0);
      q_gate = 1'b1;
      tick();
      q_gate = 1'b0; err_clr = 1'b0;
      chk("terr_set_wins", 32'(time_err), 32'd1);
      tick();
      chk("terr_held", 32'(time_err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("terr_clr2", 32'(time_err), 32'd0);

      // 6: partial ramp down then back up
      maxd = 0;
      prev_g = int'(dut.g_q);
      enable = 1'b0;
      tick();
      chk("dn_state0", 32'(ramp_state), 32'd3);
      chk("dn_g0",     32'(dut.g_q), 32'd65535);
      for (int k = 0; k < 4; k++) begin
         prev_g = int'(dut.g_q);
         tick();
         d = int'(dut.g_q) - prev_g;
         if (d < 0) d = -d;
         if (d > maxd) maxd = d;
         if (k == 0) chk("dn_g1", 32'(dut.g_q), 32'd61439);
      end
      chk("dn_g4",     32'(dut.g_q), 32'd49151);
      chk("dn_state4", 32'(ramp_state), 32'd3);
      enable = 1'b1;
      prev_g = int'(dut.g_q);
      tick();
      chk("rev_state", 32'(ramp_state), 32'd1);
      chk("rev_g",     32'(dut.g_q), 32'd49151);
      for (int k = 0; k < 4; k++) begin
         prev_g = int'(dut.g_q);
         tick();
         d = int'(dut.g_q) - prev_g;
         if (d < 0) d = -d;
         if (d > maxd) maxd = d;
      end
      chk("rev_g4",     32'(dut.g_q), 32'd65535);
      chk("rev_state4", 32'(ramp_state), 32'd1);
      tick();
      chk("rev_on",     32'(ramp_state), 32'd2);
      chk("no_jump",    32'(maxd <= 4096), 32'd1);

      // reset in the middle of a ramp-down
      enable = 1'b0;
      repeat (3) tick();
      chk("mid_g", 32'(dut.g_q), 32'd57343);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_g",     32'(dut.g_q), 32'd0);
      chk("mid_rst_state", 32'(ramp_state), 32'd0);
      chk("mid_rst_o",     {16'h0, o_data}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_gate", 32'(o_gate), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/flevel_ramp.md
Name: flevel_ramp

Overview:
- Parametrised I/Q upconverter with soft on/off amplitude ramp.
- Multiplies held I and Q baseband samples by the LO (cosd, sind) and sums them.
- Scales the sum by a ramped gain, then saturates and truncates to the output width.
- Sits between the baseband setpoint/feedforward logic and the DAC path; replaces the fixed-width unramped upconverter in new designs.

Parameters:
- DW_IN, 17: I/Q baseband width, signed.
- LO_W, 18: cosd/sind width, signed. Full-scale negative is not a legal LO value.
- DW_OUT, 16: o_data width, signed. Must satisfy DW_OUT <= DW_IN.
- GAIN_W, 16: ramp gain width, unsigned. Full gain = 2^GAIN_W-1.
- RAMP_STEP, 4096: gain increment/decrement per clk while ramping.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous, active-low reset.
- cosd, input, LO_W: LO cosine, signed.
- sind, input, LO_W: LO sine, signed.
- i_data, input, DW_IN: I baseband, signed.
- i_gate, input, 1: I sample strobe.
- q_data, input, DW_IN: Q baseband, signed.
- q_gate, input, 1: Q sample strobe.
- enable, input, 1: carrier on request (level).
- err_clr, input, 1: clears time_err and sat_cnt.
- o_data, output, DW_OUT: carrier, signed.
- o_gate, output, 1: o_data valid (carrier not idle).
- ramp_state, output, 2: FSM state.
- time_err, output, 1: sticky I/Q strobe mismatch flag.
- sat_cnt, output, 16: saturation event count.

Behaviour:
- Reset (rst_n low, async): all registers cleared. o_data=0, o_gate=0, ramp_state=IDLE, time_err=0, sat_cnt=0, gain g=0, held I/Q=0.
- Capture: i_data is loaded into hold_i on i_gate; q_data into hold_q on q_gate. Holds persist between strobes.
- time_err: set the cycle after any cycle with i_gate != q_gate. Stays set until err_clr. If err_clr and a mismatch occur in the same cycle, set wins.
- Pipeline stages (cosd/sind to o_data = 4 clk; hold to o_data = 4 clk):
  - S1: pc = hold_i*cosd, ps = hold_q*sind, each DW_IN+LO_W bits (P).
  - S2: sum = pc[P-2:LO_W-1] + ps[P-2:LO_W-1] + 1, DW_IN+1 bits (round-half-up).
  - S3: scl = (sum * {0,g}) >>> GAIN_W, DW_IN+1 bits.
  - S4: sat = scl saturated to DW_IN bits (+max / -max-1); o_data = sat[DW_IN-1:DW_IN-DW_OUT].
- Saturation event: S4 clamps a value. It feeds sat_cnt when the optional feature is built.
- Ramp FSM (ramp_state encoding IDLE=0, UP=1, ON=2, DOWN=3):
  - IDLE: g=0. enable=1 -> UP.
  - UP: g <= min(g+RAMP_STEP, 2^GAIN_W-1). -> ON in the cycle after g reaches max. enable=0 -> DOWN, checked before the step; no increment that cycle.
  - ON: g held at max. enable=0 -> DOWN.
  - DOWN: g <= max(g-RAMP_STEP, 0). -> IDLE in the cycle after g reaches 0. enable=1 -> UP from the current g (no jump).
- g is registered and applied at S3 in the following cycle.
- o_gate: ramp_state != IDLE, delayed 2 clk to align with S3/S4. Deasserts aligned with the last zero-gain output.
- Simultaneous enable edge and reset: reset wins.
- Reset mid-ramp: g returns to 0 immediately.

Optional Feature:
- Macro: FLEVEL_RAMP_SATCNT_EN.
- Defined: sat_cnt increments on each S4 saturation event and sticks at 16'hFFFF. err_clr clears it; a clear and an increment in the same cycle yields 0.
- Undefined: sat_cnt tied to 0, and no counter logic is generated.

Test Plan (default parameters):
1. Hold rst_n=0 with random inputs -> o_data=0, o_gate=0, ramp_state=0, time_err=0, sat_cnt=0. Release; outputs stay 0 while enable=0.
2. Raise enable from IDLE -> UP next cycle. g steps 4096/clk and reaches 65535 after 16 steps (saturates, not 65536). ON the following cycle. o_gate rises 2 clk after leaving IDLE.
3. In ON: hold_i=30000, hold_q=0, cosd=131071, sind=0 -> S2 sum=30000, S3 scl=29999 -> o_data=14999, steady, 4 clk after the inputs apply.
4. In ON: hold_i=hold_q=65535, cosd=sind=131071 -> positive overflow, o_data=32767. sat_cnt increments per cycle with FLEVEL_RAMP_SATCNT_EN; stays 0 without it. Pulse err_clr -> 0.
5. i_gate=1 with q_gate=0 for one cycle -> time_err=1 the next cycle and held until err_clr. err_clr coincident with a new mismatch -> time_err stays 1.
6. In ON (g=65535), drop enable for 4 cycles, then raise it -> DOWN with g=49151 after the 4 down steps, then UP. Returns to ON after 4 more steps, with no discontinuity larger than RAMP_STEP in g.
